seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request (high only in IDLE).
REQ-006 SHALL have port: sign  input  1  1 = two's-complement signed divide, 0 = unsigned; sampled at acceptance.
REQ-007 SHALL have ports: dividend, divisor  input  WIDTH  operands, sampled at acceptance.
REQ-008 SHALL have port: abort  input  1  pipeline flush; cancels any operation in flight.
REQ-009 SHALL have port: out_valid  output  1  result available (high only in DONE).
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have ports: quotient, remainder  output  WIDTH  registered results.
REQ-012 SHALL have port: div_zero  output  1  divisor was zero, valid while out_valid.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (IDLE), out_valid = (DONE).
REQ-014 SHALL accept on a rising edge with in_valid && in_ready && !abort: latch sign, operand signs, |dividend|, |divisor| (magnitudes only when sign=1), clear quotient, load counter = WIDTH, go BUSY.
REQ-015 SHALL perform one restoring-division step per BUSY cycle: trial subtract, shift quotient left, set LSB when non-negative, decrement counter.
REQ-016 SHALL, on the step where the counter reaches zero, register sign-corrected results and enter DONE; out_valid rises exactly WIDTH edges after the accept edge.
REQ-017 SHALL negate quotient when sign=1 and operand sign bits differ; remainder SHALL take the dividend's sign; unsigned mode SHALL apply no correction.
REQ-018 SHALL use only latched operands/sign for correction; input changes after acceptance SHALL have no effect.
REQ-019 SHALL hold quotient, remainder and div_zero stable while out_valid and !out_ready.
REQ-020 SHALL, in DONE with out_ready high, go IDLE on that edge; no same-edge new accept (next accept earliest one cycle later).
REQ-021 SHALL, for divisor 0, produce quotient all-ones (signed with negative dividend: quotient 1), remainder = dividend, div_zero = 1.
REQ-022 SHALL, for signed most-negative / -1, produce quotient = most-negative, remainder 0, div_zero = 0.
REQ-023 SHALL, on abort high at any edge, enter IDLE, drop out_valid, discard result; abort wins over in_valid and out_ready on the same edge.

Reset
REQ-024 SHALL, while rst_n low, immediately force IDLE, counter 0, quotient 0, remainder 0, div_zero 0, out_valid 0; in_ready SHALL be high after reset, including reset asserted mid-operation.

Configuration
REQ-025 SHALL honour macro SEQ_DIV_ZERO_FAST_EN: when defined, divisor 0 skips BUSY and enters DONE on the edge after acceptance with REQ-021 results; when undefined, divisor 0 runs the full WIDTH iterations; results and div_zero SHALL be bit-identical in both builds, only latency differs.

Verification
REQ-026 SHALL cover: WIDTH=32 unsigned 100/7 -> after 32 cycles quotient 14, remainder 2, div_zero 0.
REQ-027 SHALL cover: signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-028 SHALL cover: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned same operands -> quotient 0, remainder 0x80000000.
REQ-029 SHALL cover: 5/0 unsigned and signed -5/0 -> quotients 0xFFFFFFFF and 1, remainders 5 and 0xFFFFFFFB, div_zero 1; latency 1 with macro, 32 without.
REQ-030 SHALL cover: abort at cycle 10 of BUSY -> next cycle in_ready 1, out_valid never rises; new 9/3 then yields 3, 0.
REQ-031 SHALL cover: out_ready low 5 cycles in DONE with operand inputs toggling -> outputs stable, consumed on first out_ready edge; WIDTH=8 build 200/13 -> 15, 5 after 8 cycles.

Source files
------------

// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per cycle, signed/unsigned.
// Optional build macro: SEQ_DIV_ZERO_FAST_EN -- a zero divisor finishes one cycle
// after acceptance instead of running all WIDTH iterations.
module seq_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // acc: partial remainder; quo: dividend bits shift out as quotient bits shift in
    logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, dvs_q, dvs_d;
    logic             signed_q, signed_d, dvd_neg_q, dvd_neg_d, dvs_neg_q, dvs_neg_d;
    logic [WIDTH-1:0] quotient_d, remainder_d;
    logic             div_zero_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_step, r_step, q_mag, r_mag;
    logic             fast_zero, finish;

`ifdef SEQ_DIV_ZERO_FAST_EN
    assign fast_zero = (dvs_q == '0);
`else
    assign fast_zero = 1'b0;
`endif

    // One restoring step plus the final magnitudes for the finishing cycle
    always_comb begin
        trial = {acc_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        if (trial[WIDTH]) begin
            r_step = {acc_q[WIDTH-2:0], quo_q[WIDTH-1]};
            q_step = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            r_step = trial[WIDTH-1:0];
            q_step = {quo_q[WIDTH-2:0], 1'b1};
        end
        // Fast zero path: quo_q still holds |dividend| on the first BUSY cycle
        q_mag  = fast_zero ? '1 : q_step;
        r_mag  = fast_zero ? quo_q : r_step;
        finish = (state_q == StBusy) && (fast_zero || (cnt_q == CntOne));
    end

    // Next-state, datapath and result registration
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        signed_d    = signed_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        quotient_d  = quotient;
        remainder_d = remainder;
        div_zero_d  = div_zero;
        if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        signed_d  = sign;
                        dvd_neg_d = sign & dividend[WIDTH-1];
                        dvs_neg_d = sign & divisor[WIDTH-1];
                        quo_d     = (sign && dividend[WIDTH-1]) ? '0 - dividend : dividend;
                        dvs_d     = (sign && divisor[WIDTH-1]) ? '0 - divisor : divisor;
                        acc_d     = '0;
                        cnt_d     = CntLoad;
                        state_d   = StBusy;
                    end
                end
                StBusy: begin
                    acc_d = r_step;
                    quo_d = q_step;
                    cnt_d = cnt_q - CntOne;
                    if (finish) begin
                        cnt_d       = '0;
                        state_d     = StDone;
                        quotient_d  = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ? '0 - q_mag : q_mag;
                        remainder_d = dvd_neg_q ? '0 - r_mag : r_mag;
                        div_zero_d  = (dvs_q == '0);
                    end
                end
                StDone: begin
                    if (out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            signed_q  <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            signed_q  <= signed_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            quotient  <= quotient_d;
            remainder <= remainder_d;
            div_zero  <= div_zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (WIDTH=32 and WIDTH=8 instances).
module tb_seq_div;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SEQ_DIV_ZERO_FAST_EN
    localparam int ZeroLat = 1;
`else
    localparam int ZeroLat = 32;
`endif

    // 32-bit instance
    logic        in_valid = 0, sign = 0, abort = 0, out_ready = 0;
    logic [31:0] dividend = 0, divisor = 0;
    logic        in_ready, out_valid, div_zero;
    logic [31:0] quotient, remainder;

    seq_div #(.WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sign(sign),
        .dividend(dividend), .divisor(divisor), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    // 8-bit instance
    logic       in_valid8 = 0, sign8 = 0, abort8 = 0, out_ready8 = 0;
    logic [7:0] dividend8 = 0, divisor8 = 0;
    logic       in_ready8, out_valid8, div_zero8;
    logic [7:0] quotient8, remainder8;

    seq_div #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .sign(sign8),
        .dividend(dividend8), .divisor(divisor8), .abort(abort8), .out_valid(out_valid8),
        .out_ready(out_ready8), .quotient(quotient8), .remainder(remainder8),
        .div_zero(div_zero8)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Issue one 32-bit op, check latency, hold results `hold` cycles, then consume
    task automatic op32(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int elat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, in_ready, 1);
        in_valid = 1; sign = s; dividend = a; divisor = b; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0; sign = ~s; dividend = ~a; divisor = ~b;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, elat);
        repeat (hold) begin
            @(negedge clk);
            dividend = $urandom; divisor = $urandom; sign = $urandom_range(0, 1);
        end
        #1;
        check({tag, "_ov"}, out_valid, 1);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dz"}, div_zero, edz);
        // Consume with a new request presented on the same edge: must not be accepted
        @(negedge clk);
        out_ready = 1; in_valid = 1; dividend = 32'd1; divisor = 32'd1;
        @(posedge clk); #1;
        in_valid = 0; out_ready = 0;
        check({tag, "_done"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int lat;
        #12;
        check("rst_state", {in_ready, out_valid, div_zero}, 3'b100);
        check("rst_q", {quotient, remainder}, 64'd0);
        rst_n = 1;

        op32("u100_7",   0, 32'd100,        32'd7,          32'd14,         32'd2,          0, 32, 0);
        op32("s-7_2",    1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  0, 32, 0);
        op32("s7_-2",    1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          0, 32, 0);
        op32("s-100_-7", 1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  0, 32, 0);
        op32("smin_-1",  1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0, 32, 0);
        op32("umin_-1",  0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  0, 32, 0);
        op32("u_max_16", 0, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'd15,         0, 32, 0);
        op32("u5_0",     0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1, ZeroLat, 0);
        op32("s-5_0",    1, 32'hFFFF_FFFB,  32'd0,          32'd1,          32'hFFFF_FFFB,  1, ZeroLat, 0);
        op32("hold",     0, 32'd100,        32'd7,          32'd14,         32'd2,          0, 32, 5);

        // Abort in the 10th BUSY cycle
        @(negedge clk);
        in_valid = 1; sign = 0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        check("abort_rdy", {in_ready, out_valid}, 2'b10);
        lat = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        check("abort_nov", lat, 0);
        op32("after_abort", 0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 32, 0);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        in_valid = 1; sign = 0; dividend = 32'd77; divisor = 32'd5;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("mid_rst", {in_ready, out_valid, div_zero}, 3'b100);
        check("mid_rst_q", {quotient, remainder}, 64'd0);
        @(negedge clk);
        rst_n = 1;

        // WIDTH=8: 200/13
        @(negedge clk);
        in_valid8 = 1; sign8 = 0; dividend8 = 8'd200; divisor8 = 8'd13;
        @(posedge clk); #1;
        in_valid8 = 0; dividend8 = 8'h55; divisor8 = 8'hAA;
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8_lat", lat, 8);
        check("w8_q", quotient8, 8'd15);
        check("w8_r", remainder8, 8'd5);
        check("w8_dz", div_zero8, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
